// File: rtl/sr_flag_bank_arbiter_if.sv
// Requester-side bus of the shared SR flag bank: per-requester req/op/idx,
// bulk clear, and the registered grant/ack/flag view returned by the bank.
interface sr_flag_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 6,
  parameter int IDXW  = 3,
  parameter int GW    = 2
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      op;
  logic [NREQ*IDXW-1:0] idx;
  logic                 clr_all;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      err;
  logic                 gnt_valid;
  logic [GW-1:0]        gnt_id;
  logic [NFLAG-1:0]     flags;

  modport master (
    output req, op, idx, clr_all,
    input  ack, err, gnt_valid, gnt_id, flags
  );

  modport slave (
    input  req, op, idx, clr_all,
    output ack, err, gnt_valid, gnt_id, flags
  );
endinterface

// File: rtl/sr_flag_bank_arbiter.sv
// Round-robin shared SR flag bank: one requester transaction commits per cycle,
// and bulk clear merges into the same SR update so set always wins.

module sr_flag_bank_arbiter_cell (
  input  logic clk,
  input  logic rst,
  input  logic s_i,
  input  logic r_i,
  output logic q_o
);
  logic q_q, q_d;

  assign q_d = s_i | (q_q & ~r_i);

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

module sr_flag_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 6,
  parameter int IDXW  = 3,
  parameter int GW    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sr_flag_bank_arbiter_if.slave  bus
);
  localparam logic [IDXW:0] NFLAG_L = (IDXW+1)'(NFLAG);
  localparam logic [GW:0]   NREQ_L  = (GW+1)'(NREQ);

  logic [NREQ-1:0][IDXW-1:0] idx_v;
  logic [NREQ-1:0]           elig;
  logic [NREQ-1:0]           ack_q, ack_d, err_q, err_d;
  logic                      gnt_valid_q, gnt_any;
  logic [GW-1:0]             gnt_id_q, gnt_id_d, rr_ptr_q, rr_ptr_d, gnt_sel;
  logic [GW:0]               cand, nxt;
  logic [IDXW-1:0]           sel_idx;
  logic                      sel_op, sel_legal;
  logic [NFLAG-1:0]          idx_oh, set_mask, clr_mask, flags;

  assign idx_v = bus.idx;

  // Masking by ack keeps a requester from being granted twice while it drops req.
  assign elig = bus.req & ~ack_q;

  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (cand >= NREQ_L) cand = cand - NREQ_L;
      if (!gnt_any && elig[cand[GW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_sel = cand[GW-1:0];
      end
    end
  end

  assign sel_idx   = idx_v[gnt_sel];
  assign sel_op    = bus.op[gnt_sel];
  assign sel_legal = ({1'b0, sel_idx} < NFLAG_L);

  for (genvar f = 0; f < NFLAG; f++) begin : g_oh
    assign idx_oh[f] = (sel_idx == IDXW'(f));
  end

  always_comb begin
    set_mask = '0;
    clr_mask = {NFLAG{bus.clr_all}};
    if (gnt_any && sel_legal) begin
      if (sel_op) set_mask = idx_oh;
      else        clr_mask = clr_mask | idx_oh;
    end
  end

  always_comb begin
    ack_d    = '0;
    err_d    = '0;
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
    nxt      = {1'b0, gnt_sel} + (GW+1)'(1);
    if (nxt >= NREQ_L) nxt = '0;
    if (gnt_any) begin
      ack_d[gnt_sel] = 1'b1;
      err_d[gnt_sel] = ~sel_legal;
      gnt_id_d       = gnt_sel;
      rr_ptr_d       = nxt[GW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q       <= '0;
      err_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      ack_q       <= ack_d;
      err_q       <= err_d;
      gnt_valid_q <= gnt_any;
      gnt_id_q    <= gnt_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  for (genvar f = 0; f < NFLAG; f++) begin : g_flag
    sr_flag_bank_arbiter_cell u_cell (
      .clk (clk),
      .rst (rst),
      .s_i (set_mask[f]),
      .r_i (clr_mask[f]),
      .q_o (flags[f])
    );
  end

  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.flags     = flags;
endmodule

// File: tb/tb_sr_flag_bank_arbiter.sv
// Directed scenarios followed by randomized requester traffic, all checked
// against a transaction-level model of the flag bank and round-robin grant order.
module tb_sr_flag_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int NFLAG = 6;
  localparam int IDXW  = 3;
  localparam int GW    = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  bit            m_flags [NFLAG];
  bit [NREQ-1:0] m_ack, m_err;
  bit            m_gv;
  int            m_gid, m_ptr;

  sr_flag_bank_arbiter_if #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW), .GW(GW)) bus ();

  sr_flag_bank_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW), .GW(GW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input bit o, input int ix);
    bus.req[i] = 1'b1;
    bus.op[i]  = o;
    bus.idx[i*IDXW +: IDXW] = IDXW'(ix);
  endtask

  // Model one clock: pick the winner from the current inputs, then compare after the edge.
  task automatic step();
    int            g;
    int            ix;
    bit [NREQ-1:0] n_ack, n_err;
    bit [NFLAG-1:0] fv;
    g     = -1;
    n_ack = '0;
    n_err = '0;
    if (rst) begin
      foreach (m_flags[f]) m_flags[f] = 1'b0;
      m_ack = '0;
      m_err = '0;
      m_gv  = 1'b0;
      m_gid = 0;
      m_ptr = 0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (g < 0 && bus.req[c] && !m_ack[c]) g = c;
      end
      if (bus.clr_all) foreach (m_flags[f]) m_flags[f] = 1'b0;
      if (g >= 0) begin
        ix       = int'(bus.idx[g*IDXW +: IDXW]);
        n_ack[g] = 1'b1;
        if (ix < NFLAG) m_flags[ix] = bus.op[g];
        else            n_err[g] = 1'b1;
        m_gid = g;
        m_ptr = (g + 1) % NREQ;
      end
      m_ack = n_ack;
      m_err = n_err;
      m_gv  = (g >= 0);
    end
    @(posedge clk);
    #1;
    fv = '0;
    foreach (m_flags[f]) fv[f] = m_flags[f];
    chk("ack",       32'(bus.ack),       32'(m_ack));
    chk("err",       32'(bus.err),       32'(m_err));
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_gv));
    chk("gnt_id",    32'(bus.gnt_id),    32'(m_gid));
    chk("flags",     32'(bus.flags),     32'(fv));
  endtask

  // Let every pending requester get acked, drop it, and leave one idle cycle.
  task automatic drain();
    int n;
    n = 0;
    for (int i = 0; i < NREQ; i++) if (m_ack[i]) bus.req[i] = 1'b0;
    while (bus.req != '0 && n < 30) begin
      step();
      n++;
      for (int i = 0; i < NREQ; i++) if (m_ack[i]) bus.req[i] = 1'b0;
    end
    n_tests++;
    assert (bus.req == '0) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed pending req %b, expected 0", bus.req);
    end
    bus.req = '0;
    step();
  endtask

  initial begin
    rst         = 1'b1;
    bus.req     = '0;
    bus.op      = '0;
    bus.idx     = '0;
    bus.clr_all = 1'b0;

    // reset holds off a full set of requests
    bus.req = '1;
    step();
    step();
    chk("t1_flags", 32'(bus.flags),     32'h0);
    chk("t1_ack",   32'(bus.ack),       32'h0);
    chk("t1_gv",    32'(bus.gnt_valid), 32'h0);
    rst = 1'b0;
    step();
    chk("t1_first_ack", 32'(bus.ack), 32'h1);
    drain();

    // single set then clear
    put(0, 1'b1, 2);
    step();
    chk("t2_ack",   32'(bus.ack),    32'h1);
    chk("t2_err",   32'(bus.err),    32'h0);
    chk("t2_flags", 32'(bus.flags),  32'h04);
    chk("t2_gid",   32'(bus.gnt_id), 32'h0);
    drain();
    put(0, 1'b0, 2);
    step();
    chk("t2_clr_flags", 32'(bus.flags), 32'h00);
    drain();

    // round robin with all requesters held
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) put(i, 1'b1, i);
    step(); chk("t3_ack0", 32'(bus.ack), 32'h1);
    step(); chk("t3_ack1", 32'(bus.ack), 32'h2);
    step(); chk("t3_ack2", 32'(bus.ack), 32'h4);
    step(); chk("t3_ack3", 32'(bus.ack), 32'h8);
    chk("t3_flags", 32'(bus.flags), 32'h0f);
    step(); chk("t3_ack4", 32'(bus.ack), 32'h1);
    drain();

    // set beats bulk clear in the same cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    put(0, 1'b1, 0);
    put(1, 1'b1, 1);
    drain();
    chk("t4_pre_flags", 32'(bus.flags), 32'h03);
    put(2, 1'b1, 5);
    bus.clr_all = 1'b1;
    step();
    bus.clr_all = 1'b0;
    chk("t4_flags", 32'(bus.flags), 32'h20);
    chk("t4_ack",   32'(bus.ack),   32'h4);
    drain();

    // illegal index
    put(3, 1'b1, 7);
    step();
    chk("t5_ack",   32'(bus.ack),   32'h8);
    chk("t5_err",   32'(bus.err),   32'h8);
    chk("t5_flags", 32'(bus.flags), 32'h20);
    drain();

    // reset collides with a grant
    put(1, 1'b1, 3);
    rst = 1'b1;
    step();
    chk("t6_ack",   32'(bus.ack),   32'h0);
    chk("t6_flags", 32'(bus.flags), 32'h0);
    rst = 1'b0;
    step();
    chk("t6_ack_after", 32'(bus.ack), 32'h2);
    drain();

    // random traffic obeying the hold-until-ack rule
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst         = ($urandom_range(0, 63) == 0);
      bus.clr_all = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i] && m_ack[i]) begin
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
          else put(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end else if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
          put(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end
      end
      step();
    end
    rst         = 1'b0;
    bus.clr_all = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
